// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_pkg : shared state codes and stream constants for the loader  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package loader_pkg;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_HDR   = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_WRITE = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  localparam int c_HDR_BYTES  = 2;
  localparam int c_WORD_BYTES = 4;

  // Words of RAM available from base to the top; zero if base is already past the end.
  function automatic logic [31:0] f_room(input int depth, input int base);
    return (depth > base) ? 32'(depth - base) : 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_assembler : 8->32 MSB-first byte packer with 2-bit byte counter |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [1:0]  r_cnt;
  logic [23:0] r_word;

  // The completed word is presented combinationally so the FSM can launch the
  // write on the same edge that accepts the last byte.
  assign word_next = {r_word, byte_in};
  assign word_full = shift_en && (r_cnt == 2'(c_WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_word <= 24'd0;
    end else if (clear) begin
      r_cnt  <= 2'd0;
      r_word <= 24'd0;
    end else if (shift_en) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= word_next[23:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader : byte-stream to RAM writer, holds CPU in reset       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module program_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          MEM_DEPTH   = 1024,
  parameter logic        WRITE_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_enable,
  output logic        mem_read_write,
  output logic [15:0] mem_address,
  output logic [31:0] mem_data,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  localparam logic [31:0] c_ROOM = f_room(MEM_DEPTH, int'({16'd0, BASE_ADDR}));

  logic [2:0]  r_state;
  logic        r_hdr_cnt;
  logic [7:0]  r_hdr_hi;
  logic [15:0] r_n;
  logic [15:0] r_idx;
  logic        r_mem_enable;
  logic        r_mem_rw;
  logic [15:0] r_mem_address;
  logic [31:0] r_mem_data;
  logic        r_cpu_reset_n;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_checksum;

  logic        w_accept;
  logic        w_start;
  logic        w_shift;
  logic [15:0] w_n_next;
  logic [31:0] w_word_next;
  logic        w_word_full;

  assign byte_ready = (r_state == c_ST_HDR) || (r_state == c_ST_DATA);
  assign w_accept   = byte_valid && byte_ready;
  assign w_start    = load_start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
  assign w_shift    = w_accept && (r_state == c_ST_DATA);
  assign w_n_next   = {r_hdr_hi, byte_data};

  word_assembler u_word_assembler (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (w_start),
    .shift_en  (w_shift),
    .byte_in   (byte_data),
    .word_next (w_word_next),
    .word_full (w_word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_ST_IDLE;
      r_hdr_cnt     <= 1'b0;
      r_hdr_hi      <= 8'd0;
      r_n           <= 16'd0;
      r_idx         <= 16'd0;
      r_mem_enable  <= 1'b0;
      r_mem_rw      <= ~WRITE_LEVEL;
      r_mem_address <= 16'd0;
      r_mem_data    <= 32'd0;
      r_cpu_reset_n <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_checksum    <= 32'd0;
    end else begin
      // The write strobe is a single-cycle pulse; only DATA re-arms it.
      r_mem_enable <= 1'b0;
      r_mem_rw     <= ~WRITE_LEVEL;
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (load_start) begin
            r_state       <= c_ST_HDR;
            r_hdr_cnt     <= 1'b0;
            r_idx         <= 16'd0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_checksum    <= 32'd0;
            r_busy        <= 1'b1;
            r_cpu_reset_n <= 1'b0;
          end
        end
        c_ST_HDR: begin
          if (w_accept) begin
            if (!r_hdr_cnt) begin
              r_hdr_hi  <= byte_data;
              r_hdr_cnt <= 1'b1;
            end else begin
              r_hdr_cnt <= 1'b0;
              r_n       <= w_n_next;
              if (w_n_next == 16'd0) begin
                r_state       <= c_ST_DONE;
                r_busy        <= 1'b0;
                r_done        <= 1'b1;
                r_cpu_reset_n <= 1'b1;
              end else if ({16'd0, w_n_next} > c_ROOM) begin
                // Oversized image: nothing is written and the CPU stays in reset.
                r_state <= c_ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end else begin
                r_state <= c_ST_DATA;
              end
            end
          end
        end
        c_ST_DATA: begin
          if (w_word_full) begin
            r_state       <= c_ST_WRITE;
            r_mem_enable  <= 1'b1;
            r_mem_rw      <= WRITE_LEVEL;
            r_mem_address <= BASE_ADDR + r_idx;
            r_mem_data    <= w_word_next;
          end
        end
        c_ST_WRITE: begin
          r_checksum <= r_checksum + r_mem_data;
          r_idx      <= r_idx + 16'd1;
          if ((r_idx + 16'd1) == r_n) begin
            r_state       <= c_ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_cpu_reset_n <= 1'b1;
          end else begin
            r_state <= c_ST_DATA;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_enable     = r_mem_enable;
  assign mem_read_write = r_mem_rw;
  assign mem_address    = r_mem_address;
  assign mem_data       = r_mem_data;
  assign cpu_reset_n    = r_cpu_reset_n;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign checksum       = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_program_loader : directed bench for program_loader (two bases)    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        load_start_lo, load_start_hi;

  logic        byte_ready_lo, mem_enable_lo, mem_rw_lo, cpu_reset_n_lo, busy_lo, done_lo, err_lo;
  logic [15:0] mem_address_lo;
  logic [31:0] mem_data_lo, checksum_lo;
  logic        byte_ready_hi, mem_enable_hi, mem_rw_hi, cpu_reset_n_hi, busy_hi, done_hi, err_hi;
  logic [15:0] mem_address_hi;
  logic [31:0] mem_data_hi, checksum_hi;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(16'h0000), .MEM_DEPTH(1024), .WRITE_LEVEL(1'b1)) u_dut_lo (
    .clk(clk), .reset(reset), .load_start(load_start_lo), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready_lo), .mem_enable(mem_enable_lo),
    .mem_read_write(mem_rw_lo), .mem_address(mem_address_lo), .mem_data(mem_data_lo),
    .cpu_reset_n(cpu_reset_n_lo), .busy(busy_lo), .done(done_lo), .err(err_lo),
    .checksum(checksum_lo)
  );

  program_loader #(.BASE_ADDR(16'h0300), .MEM_DEPTH(1024), .WRITE_LEVEL(1'b1)) u_dut_hi (
    .clk(clk), .reset(reset), .load_start(load_start_hi), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready_hi), .mem_enable(mem_enable_hi),
    .mem_read_write(mem_rw_hi), .mem_address(mem_address_hi), .mem_data(mem_data_hi),
    .cpu_reset_n(cpu_reset_n_hi), .busy(busy_hi), .done(done_hi), .err(err_hi),
    .checksum(checksum_hi)
  );

  // RAM models and strobe bookkeeping, sampled on the falling edge
  logic [31:0] ram_lo [0:1023];
  logic [31:0] ram_hi [0:1023];
  int wr_lo = 0, wr_hi = 0, dup_lo = 0, rdy_lo = 0, dir_bad = 0;
  int cyc = 0, last_cyc_lo = 0, last_gap_lo = 0;
  logic        prev_en_lo = 1'b0;
  logic [15:0] first_addr_hi = 16'hFFFF, last_addr_hi = 16'hFFFF;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_rw_lo !== mem_enable_lo) dir_bad++;
    if (mem_rw_hi !== mem_enable_hi) dir_bad++;
    if (mem_enable_lo) begin
      ram_lo[mem_address_lo[9:0]] = mem_data_lo;
      wr_lo++;
      if (prev_en_lo) dup_lo++;
      if (byte_ready_lo) rdy_lo++;
      last_gap_lo = cyc - last_cyc_lo;
      last_cyc_lo = cyc;
    end
    prev_en_lo = mem_enable_lo;
    if (mem_enable_hi) begin
      if (wr_hi == 0) first_addr_hi = mem_address_hi;
      last_addr_hi = mem_address_hi;
      ram_hi[mem_address_hi[9:0]] = mem_data_hi;
      wr_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic send_byte(input bit hi, input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (!(hi ? byte_ready_hi : byte_ready_lo) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit hi);
    if (hi) load_start_hi = 1'b1; else load_start_lo = 1'b1;
    @(negedge clk);
    load_start_hi = 1'b0;
    load_start_lo = 1'b0;
  endtask

  task automatic wait_done(input bit hi);
    int n;
    n = 0;
    while (!(hi ? done_hi : done_lo) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("done_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] s1 [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic send_s1(input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++)
      send_byte(1'b0, s1[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic check_s1(input string tag, input int wr_base);
    check({tag, "_ram0"}, ram_lo[0], 32'h12345678);
    check({tag, "_ram1"}, ram_lo[1], 32'hDEADBEEF);
    check({tag, "_writes"}, 32'(wr_lo - wr_base), 32'd2);
    check({tag, "_checksum"}, checksum_lo, 32'hF0E21567);
    check({tag, "_done"}, {31'd0, done_lo}, 32'd1);
    check({tag, "_err"}, {31'd0, err_lo}, 32'd0);
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_reset_n_lo}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_lo}, 32'd0);
  endtask

  initial begin
    int base;
    logic [31:0] w, sum;
    reset = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    load_start_lo = 1'b0;
    load_start_hi = 1'b0;
    for (int i = 0; i < 1024; i++) begin ram_lo[i] = '0; ram_hi[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_lo}, 32'd0);
    check("rst_rw", {31'd0, mem_rw_lo}, 32'd0);
    check("rst_cpu_rst_n", {31'd0, cpu_reset_n_lo}, 32'd0);
    check("rst_ready", {31'd0, byte_ready_lo}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: basic two-word load, back-to-back bytes
    base = wr_lo;
    pulse_start(1'b0);
    check("t1_busy", {31'd0, busy_lo}, 32'd1);
    send_s1(0, 9, 0);
    wait_done(1'b0);
    check_s1("t1", base);
    check("t1_word_period", 32'(last_gap_lo), 32'd5);

    // 2: empty image
    base = wr_lo;
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    check("t2_done_now", {31'd0, done_lo}, 32'd1);
    check("t2_err", {31'd0, err_lo}, 32'd0);
    check("t2_cpu_rst_n", {31'd0, cpu_reset_n_lo}, 32'd1);
    check("t2_writes", 32'(wr_lo - base), 32'd0);
    check("t2_checksum", checksum_lo, 32'd0);

    // 3: capacity boundary at base 0x300 (256 words of room)
    pulse_start(1'b1);
    send_byte(1'b1, 8'h01, 0);
    send_byte(1'b1, 8'h01, 0);
    check("t3_ovf_done", {31'd0, done_hi}, 32'd1);
    check("t3_ovf_err", {31'd0, err_hi}, 32'd1);
    check("t3_ovf_cpu_rst_n", {31'd0, cpu_reset_n_hi}, 32'd0);
    check("t3_ovf_writes", 32'(wr_hi), 32'd0);
    pulse_start(1'b1);
    send_byte(1'b1, 8'h01, 0);
    send_byte(1'b1, 8'h00, 0);
    sum = 32'd0;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i) ^ 8'hA5, ~8'(i), 8'(i + 3)};
      sum = sum + w;
      for (int k = 3; k >= 0; k--) send_byte(1'b1, w[8*k +: 8], 0);
    end
    wait_done(1'b1);
    check("t3_writes", 32'(wr_hi), 32'd256);
    check("t3_first_addr", {16'd0, first_addr_hi}, 32'h0300);
    check("t3_last_addr", {16'd0, last_addr_hi}, 32'h03FF);
    check("t3_last_word", ram_hi[1023], 32'hFF5A0002);
    check("t3_checksum", checksum_hi, sum);
    check("t3_err", {31'd0, err_hi}, 32'd0);
    check("t3_cpu_rst_n", {31'd0, cpu_reset_n_hi}, 32'd1);

    // 4: random valid gaps
    ram_lo[0] = '0;
    ram_lo[1] = '0;
    base = wr_lo;
    pulse_start(1'b0);
    send_s1(0, 9, 3);
    wait_done(1'b0);
    check_s1("t4", base);
    check("t4_ready_in_write", 32'(rdy_lo), 32'd0);
    check("t4_strobe_len", 32'(dup_lo), 32'd0);

    // 5: asynchronous reset after two data bytes
    base = wr_lo;
    pulse_start(1'b0);
    send_s1(0, 3, 0);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy_lo}, 32'd0);
    check("t5_done", {31'd0, done_lo}, 32'd0);
    check("t5_addr", {16'd0, mem_address_lo}, 32'd0);
    check("t5_data", mem_data_lo, 32'd0);
    check("t5_rw", {31'd0, mem_rw_lo}, 32'd0);
    check("t5_ready", {31'd0, byte_ready_lo}, 32'd0);
    check("t5_cpu_rst_n_hi", {31'd0, cpu_reset_n_hi}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_partial_writes", 32'(wr_lo - base), 32'd0);
    ram_lo[0] = '0;
    ram_lo[1] = '0;
    base = wr_lo;
    pulse_start(1'b0);
    send_s1(0, 9, 0);
    wait_done(1'b0);
    check_s1("t5", base);

    // 6: load_start ignored mid-load, honoured in DONE
    base = wr_lo;
    pulse_start(1'b0);
    send_s1(0, 2, 0);
    pulse_start(1'b0);
    send_s1(3, 9, 0);
    wait_done(1'b0);
    check_s1("t6a", base);
    pulse_start(1'b0);
    check("t6_restart_done", {31'd0, done_lo}, 32'd0);
    check("t6_restart_checksum", checksum_lo, 32'd0);
    check("t6_restart_cpu_rst_n", {31'd0, cpu_reset_n_lo}, 32'd0);
    check("t6_restart_busy", {31'd0, busy_lo}, 32'd1);
    ram_lo[0] = '0;
    ram_lo[1] = '0;
    base = wr_lo;
    send_s1(0, 9, 0);
    wait_done(1'b0);
    check_s1("t6b", base);

    check("direction", 32'(dir_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
